// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the FP32 divider back end.
// Holds the special-operand classification, the binary32 constants and
// the payload structs carried between the post-normalize pipeline stages.
package fp32_div_pkg;

  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_e;

  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  // Stage 1 -> stage 2: normalized significand with guard/sticky, exponent
  // already corrected for the operand shifts and the quotient normalization.
  typedef struct packed {
    logic               sign;
    special_e           special;
    logic signed [11:0] expo;
    logic [23:0]        mant;
    logic               guard;
    logic               sticky;
  } s1_t;

  // Stage 2 -> stage 3: rounded significand and final exponent. tiny marks a
  // result that is still subnormal (or zero) after rounding.
  typedef struct packed {
    logic               sign;
    special_e           special;
    logic signed [11:0] expo;
    logic [23:0]        mant;
    logic               inexact;
    logic               tiny;
  } s2_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a 24-bit significand.
// Ports: mant_i/guard_i/sticky_i in; mant_o (low 24 bits of the sum),
//        carry_o (overflow out of bit 23), inexact_o (any discarded bit set).
module fp_round_rne (
  input  logic [23:0] mant_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  output logic [23:0] mant_o,
  output logic        carry_o,
  output logic        inexact_o
);

  logic        round_up;
  logic [24:0] sum;

  // Ties (guard set, sticky clear) only round up when the LSB is odd.
  assign round_up  = guard_i & (sticky_i | mant_i[0]);
  assign sum       = {1'b0, mant_i} + {24'b0, round_up};
  assign mant_o    = sum[23:0];
  assign carry_o   = sum[24];
  assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fp_div_postnorm_pack.sv
// FP32 divider back end: renormalize quotient, denormalize tiny results,
// round RNE and pack binary32 with {overflow, underflow, inexact} flags.
// Ports: in_valid/in_ready + quotient, remainder sticky, exponent, operand
//        shifts, sign, special class; out_valid/out_ready + result, flags.
// Three register stages that all advance together whenever the output is
// empty or being consumed; a stalled output freezes the whole pipe.
module fp_div_postnorm_pack
  import fp32_div_pkg::*;
#(
  parameter int QW              = 27,
  parameter bit FLUSH_SUBNORMAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q_mant,
  input  logic          rem_nz,
  input  logic [9:0]    exp_in,
  input  logic [4:0]    dvd_shift,
  input  logic [4:0]    dvs_shift,
  input  logic          sign_in,
  input  logic [1:0]    special_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   result,
  output logic [2:0]    flags
);

  localparam logic signed [11:0] EXP_MAX_S = 12'(FP32_EXP_MAX);

  logic        en;
  logic        s1_vld_q, s2_vld_q, out_vld_q;
  s1_t         s1_q, s1_d;
  s2_t         s2_q, s2_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  assign en        = !out_vld_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_vld_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // ---------------------------------------------------------------- S1
  logic signed [11:0] e_adj;
  logic [QW-1:0]      q_norm;

  always_comb begin
    e_adj = {{2{exp_in[9]}}, exp_in} - {7'b0, dvd_shift} + {7'b0, dvs_shift};
    // Quotient lies in [0.5,2); bring the leading one to the 2^0 position.
    if (q_mant[QW-1]) begin
      q_norm = q_mant;
    end else begin
      q_norm = q_mant << 1;
      e_adj  = e_adj - 12'sd1;
    end
    s1_d         = '0;
    s1_d.sign    = sign_in;
    s1_d.special = special_e'(special_in);
    s1_d.expo    = e_adj;
    s1_d.mant    = q_norm[QW-1 -: 24];
    s1_d.guard   = q_norm[QW-25];
    s1_d.sticky  = (|q_norm[QW-26:0]) | rem_nz;
  end

  // ---------------------------------------------------------------- S2
  logic signed [11:0] e1;
  logic signed [11:0] sh_full;
  logic [4:0]         sh;
  logic               sub;
  logic [24:0]        mg, mg_sh;
  logic               lost;
  logic [23:0]        m_pre, m_rnd;
  logic               g_pre, s_pre, rnd_carry, rnd_inexact;

  always_comb begin
    e1      = s1_q.expo;
    sub     = (e1 <= 12'sd0);
    sh_full = 12'sd1 - e1;
    sh      = 5'd0;
    if (sub) begin
      // Beyond 25 every significand bit lands in sticky anyway.
      sh = (sh_full >= 12'sd25) ? 5'd25 : sh_full[4:0];
    end
    // Shift significand and guard together; anything pushed past guard
    // becomes sticky.
    mg    = {s1_q.mant, s1_q.guard};
    mg_sh = mg >> sh;
    lost  = |(mg & ~({25{1'b1}} << sh));
    m_pre = mg_sh[24:1];
    g_pre = mg_sh[0];
    s_pre = s1_q.sticky | lost;
  end

  fp_round_rne u_round (
    .mant_i    (m_pre),
    .guard_i   (g_pre),
    .sticky_i  (s_pre),
    .mant_o    (m_rnd),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.special = s1_q.special;
    s2_d.inexact = rnd_inexact;
    if (sub) begin
      // A subnormal that rounds into bit 23 is the minimum normal.
      s2_d.mant = m_rnd;
      s2_d.expo = m_rnd[23] ? 12'sd1 : 12'sd0;
      s2_d.tiny = !m_rnd[23];
    end else begin
      // Carry out of bit 23 means the significand became 2.0: renormalize.
      s2_d.mant = rnd_carry ? {1'b1, m_rnd[23:1]} : m_rnd;
      s2_d.expo = rnd_carry ? (e1 + 12'sd1) : e1;
      s2_d.tiny = 1'b0;
    end
  end

  // ---------------------------------------------------------------- S3
  logic signed [11:0] e2;

  always_comb begin
    e2       = s2_q.expo;
    result_d = '0;
    flags_d  = '0;
    case (s2_q.special)
      SP_ZERO: result_d = {s2_q.sign, 31'h0};
      SP_INF:  result_d = {s2_q.sign, 8'hFF, 23'h0};
      SP_NAN:  result_d = FP32_QNAN;
      default: begin
        if (s2_q.tiny) begin
          if (FLUSH_SUBNORMAL) begin
            result_d = {s2_q.sign, 31'h0};
            flags_d  = 3'b011;
          end else begin
            result_d = {s2_q.sign, 8'h00, s2_q.mant[22:0]};
            flags_d  = {1'b0, s2_q.inexact, s2_q.inexact};
          end
        end else if (e2 >= EXP_MAX_S) begin
          result_d = {s2_q.sign, 8'hFF, 23'h0};
          flags_d  = 3'b101;
        end else begin
          result_d = {s2_q.sign, e2[7:0], s2_q.mant[22:0]};
          flags_d  = {2'b00, s2_q.inexact};
        end
      end
    endcase
  end

  // ---------------------------------------------------------------- regs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      result_q  <= 32'h0;
      flags_q   <= 3'b0;
    end else if (en) begin
      s1_vld_q  <= in_valid;
      s2_vld_q  <= s1_vld_q;
      out_vld_q <= s2_vld_q;
      if (in_valid) s1_q <= s1_d;
      if (s1_vld_q) s2_q <= s2_d;
      if (s2_vld_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

endmodule
